btn_event_decoder: RTL

- Consumes the clean, debounced button level from the button anti-jitter stage and turns it into single-cycle user-input events.
- Events: press, release, long-press and optional auto-repeat.
- Also keeps a wrapping press counter and a held level.
- Sits between the debouncer output and the control FSMs / display logic. All logic runs in the same clock domain as the debouncer.

---
 rtl/btn_event_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder
// Turns a clean, debounced button level into single-cycle press, release,
// long-press and (optionally) auto-repeat events. Also keeps a wrapping
// 8-bit press counter and a registered "held" level.
// Optional feature: define BTN_AUTO_REPEAT_EN to emit repeat_pulse every
// REPEAT_CYCLES cycles while the button stays in long-hold. When undefined,
// repeat_pulse is tied low and no repeat logic exists.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTN_IN,
  input  logic       cnt_clr,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_LONG    = 2'd2;

  // Terminal counts: the hold counter starts at 0, so the event fires
  // on the edge where the counter reads (period - 1).
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             press_next;
  logic             release_next;
  logic             long_next;
  logic             held_next;
  logic [7:0]       count_next;
`ifdef BTN_AUTO_REPEAT_EN
  logic             repeat_next;
`endif

  // Next-state / next-output decode; every pulse defaults low so it lasts one cycle
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    held_next    = held;
`ifdef BTN_AUTO_REPEAT_EN
    repeat_next  = 1'b0;
`endif
    // Clear first, so a clear coinciding with a press still counts the press
    count_next   = cnt_clr ? 8'd0 : press_count;

    case (state_reg)
      S_IDLE: begin
        if (BTN_IN) begin
          state_next = S_PRESSED;
          press_next = 1'b1;
          held_next  = 1'b1;
          cnt_next   = '0;
          count_next = count_next + 8'd1;
        end
      end
      S_PRESSED: begin
        // Release has priority over reaching the long-press threshold
        if (!BTN_IN) begin
          state_next   = S_IDLE;
          release_next = 1'b1;
          held_next    = 1'b0;
        end else if (cnt_reg == LONG_LAST) begin
          state_next = S_LONG;
          long_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_LONG: begin
        if (!BTN_IN) begin
          state_next   = S_IDLE;
          release_next = 1'b1;
          held_next    = 1'b0;
          cnt_next     = '0;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt_reg == REPEAT_LAST) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        held_next  = 1'b0;
      end
    endcase
  end

  // State, hold counter and registered outputs; reset aborts any hold silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
      held          <= held_next;
      press_count   <= count_next;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  // Auto-repeat pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_next;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
